// File: rtl/div_pkg.sv
// Shared definitions for the sequential 2W-by-W restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Quotient reported whenever the true quotient cannot fit (includes divide-by-zero)
  localparam logic [DIV_WIDTH-1:0] OVF_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_prem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_prem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;

  // prem is always below the divisor, so its top bit is zero and the trial value
  // never exceeds WIDTH+1 significant bits; the extra bit only keeps the compare exact.
  assign w_trial = {i_prem, i_bit};
  assign w_diff  = w_trial - {2'b00, i_divisor};
  assign o_qbit  = (w_trial >= {2'b00, i_divisor});
  assign o_prem  = (WIDTH+1)'(o_qbit ? w_diff : w_trial);

endmodule

// File: rtl/divider64by32_seq.sv
// Sequential unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, valid/ready handshake on input and output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for an operation
// ST_BUSY | one restoring step per cycle, counter runs WIDTH-1 down to 0
// ST_DONE | out_valid=1, result held until out_ready
module divider64by32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               dbz
);

  localparam int unsigned      CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    L_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] L_OVF_QUOT = {WIDTH{&OVF_QUOT}};

  div_state_t       r_state;
  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_ovf;
  logic             r_dbz;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_prem_nxt;
  logic             w_qbit;

  assign w_hi = dividend[2*WIDTH-1:WIDTH];
  assign w_lo = dividend[WIDTH-1:0];

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_shreg[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_prem    (w_prem_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prem      <= '0;
      r_shreg     <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_divisor  <= divisor;
            // High half >= divisor means the quotient needs more than WIDTH bits
            if (w_hi >= divisor) begin
              r_quot      <= L_OVF_QUOT;
              r_rem       <= w_hi;
              r_ovf       <= 1'b1;
              r_dbz       <= (divisor == '0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_prem  <= {1'b0, w_hi};
              r_shreg <= w_lo;
              r_cnt   <= L_CNT_LAST;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom
          r_prem  <= w_prem_nxt;
          r_shreg <= {r_shreg[WIDTH-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_quot      <= {r_shreg[WIDTH-2:0], w_qbit};
            r_rem       <= w_prem_nxt[WIDTH-1:0];
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule
